// File: rtl/inst_fetch_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inst_fetch_ctrl_pkg                                                        |
// | Shared bus macros, fetch FSM encoding and helpers for inst_fetch_ctrl.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`ifndef INST_FETCH_CTRL_DEFINES
`define INST_FETCH_CTRL_DEFINES
`define InstAddrBus 31:0
`define InstBus     31:0
`define InstWidth   32
`define ChipEnable  1'b1
`define ChipDisable 1'b0
`define FsmIdle     2'b00
`define FsmFetch    2'b01
`define FsmHalt     2'b10
`endif

package inst_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = `FsmIdle,
    S_FETCH = `FsmFetch,
    S_HALT  = `FsmHalt
  } fetch_state_e;

  localparam logic [`InstAddrBus] c_pc_step = 32'd4;

  // Redirect targets are always forced onto a word boundary.
  function automatic logic [`InstAddrBus] word_align(input logic [`InstAddrBus] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetch_ctrl_if_id_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | if_id_reg                                                                  |
// | Fetch/decode pipeline register with load, flush (bubble) and invalidate.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module if_id_reg (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               flush,
  input  logic               drop,
  input  logic [`InstAddrBus] pc_in,
  input  logic [`InstBus]     inst_in,
  output logic [`InstAddrBus] id_pc,
  output logic [`InstBus]     id_inst,
  output logic               id_valid
);

  logic [`InstAddrBus] id_pc_q,    id_pc_d;
  logic [`InstBus]     id_inst_q,  id_inst_d;
  logic               id_valid_q, id_valid_d;

  // Flush outranks load; with no control asserted the register holds.
  always_comb begin
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    if (flush) begin
      id_inst_d  = '0;
      id_valid_d = 1'b0;
    end else if (load) begin
      id_pc_d    = pc_in;
      id_inst_d  = inst_in;
      id_valid_d = 1'b1;
    end else if (drop) begin
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_pc_q    <= '0;
      id_inst_q  <= '0;
      id_valid_q <= 1'b0;
    end else begin
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;
  assign id_valid = id_valid_q;

endmodule
`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inst_fetch_ctrl                                                            |
// | Instruction fetch FSM: PC sequencing, stall/branch handling, ROM-end halt. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter logic [`InstAddrBus] RESET_PC  = 32'h0000_0000,
  parameter int unsigned         MEM_WORDS = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_flag,
  input  logic [`InstAddrBus] branch_target_addr,
  input  logic [`InstBus]     inst,
  output logic               ce,
  output logic [`InstAddrBus] inst_addr,
  output logic [`InstAddrBus] id_pc,
  output logic [`InstBus]     id_inst,
  output logic               id_valid,
  output logic               halted
);

  localparam logic [`InstWidth-3:0] c_last_word = (`InstWidth-2)'(MEM_WORDS - 1);

  fetch_state_e        state_q,  state_d;
  logic [`InstAddrBus] pc_q,     pc_d;
  logic               ce_q,     ce_d;
  logic               halted_q, halted_d;

  logic w_load;
  logic w_flush;
  logic w_drop;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    w_load  = 1'b0;
    w_flush = 1'b0;
    w_drop  = 1'b0;
    if (branch_flag) begin
      pc_d    = word_align(branch_target_addr);
      w_flush = 1'b1;
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_FETCH;
        S_FETCH: begin
          if (!stall) begin
            w_load = 1'b1;
            pc_d   = pc_q + c_pc_step;
            // The word at the last ROM slot is still delivered before halting.
            if (pc_q[`InstWidth-1:2] == c_last_word) state_d = S_HALT;
          end
        end
        S_HALT:  w_drop = 1'b1;
        default: state_d = S_IDLE;
      endcase
    end
    ce_d     = (state_d == S_FETCH) ? `ChipEnable : `ChipDisable;
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      ce_q     <= `ChipDisable;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ce_q     <= ce_d;
      halted_q <= halted_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .flush    (w_flush),
    .drop     (w_drop),
    .pc_in    (pc_q),
    .inst_in  (inst),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .id_valid (id_valid)
  );

  assign ce        = ce_q;
  assign inst_addr = pc_q;
  assign halted    = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_inst_fetch_ctrl                                                         |
// | Directed self-checking bench: sequencing, stall, branch, halt, wrap, reset.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_inst_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Default-parameter instance
  logic        rst0 = 1'b0, stall0 = 1'b0, br0 = 1'b0;
  logic [31:0] tgt0 = '0;
  logic [31:0] inst0, addr0, id_pc0, id_inst0;
  logic        ce0, id_valid0, halted0;

  // High-address instance for PC wrap
  logic        rst1 = 1'b0, stall1 = 1'b0, br1 = 1'b0;
  logic [31:0] tgt1 = '0;
  logic [31:0] inst1, addr1, id_pc1, id_inst1;
  logic        ce1, id_valid1, halted1;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'hA5A5_0000 ^ a;
  endfunction

  assign inst0 = rom(addr0);
  assign inst1 = rom(addr1);

  inst_fetch_ctrl #(.RESET_PC(32'h0000_0000), .MEM_WORDS(6)) dut0 (
    .clk(clk), .rst(rst0), .stall(stall0), .branch_flag(br0),
    .branch_target_addr(tgt0), .inst(inst0), .ce(ce0), .inst_addr(addr0),
    .id_pc(id_pc0), .id_inst(id_inst0), .id_valid(id_valid0), .halted(halted0)
  );

  inst_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .MEM_WORDS(1024)) dut1 (
    .clk(clk), .rst(rst1), .stall(stall1), .branch_flag(br1),
    .branch_target_addr(tgt1), .inst(inst1), .ce(ce1), .inst_addr(addr1),
    .id_pc(id_pc1), .id_inst(id_inst1), .id_valid(id_valid1), .halted(halted1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Snapshot of the default instance: ce, inst_addr, id_valid, id_pc, halted
  task automatic st0(input string tag, input logic e_ce, input logic [31:0] e_addr,
                     input logic e_v, input logic [31:0] e_pc, input logic e_h);
    chk({tag, ".ce"},       {31'd0, ce0},       {31'd0, e_ce});
    chk({tag, ".addr"},     addr0,              e_addr);
    chk({tag, ".id_valid"}, {31'd0, id_valid0}, {31'd0, e_v});
    chk({tag, ".id_pc"},    id_pc0,             e_pc);
    chk({tag, ".halted"},   {31'd0, halted0},   {31'd0, e_h});
  endtask

  initial begin
    // Reset held
    tick(); tick();
    st0("rst_hold", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("rst_hold.id_inst", id_inst0, 32'h0);
    rst0 = 1'b1;
    tick();  // IDLE exit edge
    st0("fetch0", 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    st0("fetch1", 1'b1, 32'h4, 1'b1, 32'h0, 1'b0);
    chk("fetch1.id_inst", id_inst0, rom(32'h0));
    tick();
    st0("fetch2", 1'b1, 32'h8, 1'b1, 32'h4, 1'b0);
    chk("fetch2.id_inst", id_inst0, rom(32'h4));

    // Stall three cycles at pc=8
    stall0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      st0($sformatf("stall%0d", i), 1'b1, 32'h8, 1'b1, 32'h4, 1'b0);
    end
    stall0 = 1'b0;
    tick();
    st0("resume", 1'b1, 32'hC, 1'b1, 32'h8, 1'b0);
    chk("resume.id_inst", id_inst0, rom(32'h8));

    // Branch beats stall; target low bits dropped
    br0 = 1'b1; stall0 = 1'b1; tgt0 = 32'h0000_0007;
    tick();
    br0 = 1'b0; stall0 = 1'b0;
    st0("branch", 1'b1, 32'h4, 1'b0, 32'h8, 1'b0);
    chk("branch.id_inst", id_inst0, 32'h0);
    tick();
    st0("br_tgt", 1'b1, 32'h8, 1'b1, 32'h4, 1'b0);
    tick(); tick(); tick();
    st0("pre_end", 1'b1, 32'h14, 1'b1, 32'h10, 1'b0);

    // Last ROM word delivered, then halt
    tick();
    st0("last", 1'b0, 32'h18, 1'b1, 32'h14, 1'b1);
    chk("last.id_inst", id_inst0, rom(32'h14));
    tick();
    st0("halt", 1'b0, 32'h18, 1'b0, 32'h14, 1'b1);
    tick();
    st0("halt_hold", 1'b0, 32'h18, 1'b0, 32'h14, 1'b1);

    // Branch out of HALT
    br0 = 1'b1; tgt0 = 32'h0;
    tick();
    br0 = 1'b0;
    st0("unhalt", 1'b1, 32'h0, 1'b0, 32'h14, 1'b0);
    tick();
    st0("refetch", 1'b1, 32'h4, 1'b1, 32'h0, 1'b0);

    // Asynchronous reset between edges during stall
    stall0 = 1'b1;
    tick();
    st0("pre_arst", 1'b1, 32'h4, 1'b1, 32'h0, 1'b0);
    #2 rst0 = 1'b0;
    #1;
    st0("arst", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("arst.id_inst", id_inst0, 32'h0);
    stall0 = 1'b0;
    tick();
    rst0 = 1'b1;
    st0("arst_idle", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    st0("arst_fetch", 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    st0("arst_run", 1'b1, 32'h4, 1'b1, 32'h0, 1'b0);

    // PC wrap on the high-address instance
    chk("wrap_rst.addr", addr1, 32'hFFFF_FFF8);
    rst1 = 1'b1;
    tick();
    chk("wrap0.ce",   {31'd0, ce1}, 32'd1);
    chk("wrap0.addr", addr1, 32'hFFFF_FFF8);
    tick();
    chk("wrap1.addr",  addr1,  32'hFFFF_FFFC);
    chk("wrap1.id_pc", id_pc1, 32'hFFFF_FFF8);
    tick();
    chk("wrap2.addr",    addr1,    32'h0000_0000);
    chk("wrap2.id_pc",   id_pc1,   32'hFFFF_FFFC);
    chk("wrap2.id_inst", id_inst1, rom(32'hFFFF_FFFC));
    tick();
    chk("wrap3.addr",   addr1,   32'h0000_0004);
    chk("wrap3.halted", {31'd0, halted1}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
